// File: rtl/compress_pkg.sv
// Shared definitions for the compress packer: code constants, code-to-length map, FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package compress_pkg;

    localparam logic [1:0] BM_ZERO = 2'b00;
    localparam logic [1:0] BM_8    = 2'b01;
    localparam logic [1:0] BM_16   = 2'b10;
    localparam logic [1:0] BM_32   = 2'b11;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Number of payload bytes carried by a compression code (0, 1, 2 or 4).
    function automatic logic [2:0] code_len(input logic [1:0] code);
        logic [2:0] len;
        len = 3'd0;
        case (code)
            BM_ZERO: len = 3'd0;
            BM_8:    len = 3'd1;
            BM_16:   len = 3'd2;
            BM_32:   len = 3'd4;
            default: len = 3'd0;
        endcase
        return len;
    endfunction

    // Payload with bytes beyond the code's length forced to zero, so they
    // can be OR-ed straight into the accumulator.
    function automatic logic [31:0] code_bytes(input logic [1:0] code, input logic [31:0] data);
        logic [31:0] b;
        b = 32'd0;
        case (code)
            BM_ZERO: b = 32'd0;
            BM_8:    b = {24'd0, data[7:0]};
            BM_16:   b = {16'd0, data[15:0]};
            BM_32:   b = data;
            default: b = 32'd0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/compress_bm_packer.sv
// Packs 2-bit codes into 16-field words and holds them in the bitmap output register.
// Latency: a word is valid the cycle after the edge that accepts its 16th code or flushes it.
// Backpressure: output register holds until i_bm_rdy; caller must not send the 16th code while it is full.
// Ports: i_code_vld/i_code/i_last = accepted code; i_flush = end of frame, emit partial word;
//        o_bm_* = bitmap channel; o_cnt = codes pending; o_fin_load = partial word loads this cycle.
module compress_bm_packer
    import compress_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_code_vld,
    input  logic [1:0]  i_code,
    input  logic        i_last,
    input  logic        i_flush,
    input  logic        i_bm_rdy,
    output logic        o_bm_vld,
    output logic [31:0] o_bm_dat,
    output logic [4:0]  o_bm_nfields,
    output logic        o_bm_last,
    output logic [3:0]  o_cnt,
    output logic        o_fin_load
);

    logic [31:0] r_acc;
    logic [3:0]  r_cnt;
    logic        r_vld;
    logic [31:0] r_dat;
    logic [4:0]  r_nfields;
    logic        r_last;

    logic        w_free;
    logic        w_fin_load;
    logic [31:0] w_word;

    assign w_free     = !r_vld || i_bm_rdy;
    assign w_fin_load = i_flush && !i_code_vld && (r_cnt != 4'd0) && w_free;
    assign w_word     = r_acc | ({30'd0, i_code} << {r_cnt, 1'b0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= 32'd0;
            r_cnt     <= 4'd0;
            r_vld     <= 1'b0;
            r_dat     <= 32'd0;
            r_nfields <= 5'd0;
            r_last    <= 1'b0;
        end else begin
            if (r_vld && i_bm_rdy) begin
                r_vld <= 1'b0;
            end
            if (i_code_vld) begin
                if (r_cnt == 4'd15) begin
                    // 16th code completes the word; it is the frame's final word if this is the last beat.
                    r_vld     <= 1'b1;
                    r_dat     <= w_word;
                    r_nfields <= 5'd16;
                    r_last    <= i_last;
                    r_acc     <= 32'd0;
                    r_cnt     <= 4'd0;
                end else begin
                    r_acc <= w_word;
                    r_cnt <= r_cnt + 4'd1;
                end
            end else if (w_fin_load) begin
                r_vld     <= 1'b1;
                r_dat     <= r_acc;
                r_nfields <= {1'b0, r_cnt};
                r_last    <= 1'b1;
                r_acc     <= 32'd0;
                r_cnt     <= 4'd0;
            end
        end
    end

    assign o_bm_vld     = r_vld;
    assign o_bm_dat     = r_dat;
    assign o_bm_nfields = r_nfields;
    assign o_bm_last    = r_last;
    assign o_cnt        = r_cnt;
    assign o_fin_load   = w_fin_load;

endmodule

// File: rtl/compress_packer.sv
// Packs variable-length compressed elements into 32-bit payload words and 16-code bitmap words.
// Latency: a completed word is valid the cycle after the accepting edge; frame tail words follow in FLUSH.
// Backpressure: in_ready drops when the byte accumulator cannot take 4 more bytes or the bitmap word cannot retire.
// Ports: in_* = element stream (code, right-aligned data, frame end); pay_* = packed bytes;
//        bm_* = packed codes. clk rising edge, rst_n async active low.
module compress_packer
    import compress_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_bitmap,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        pay_valid,
    input  logic        pay_ready,
    output logic [31:0] pay_data,
    output logic [2:0]  pay_nbytes,
    output logic        pay_last,
    output logic        bm_valid,
    input  logic        bm_ready,
    output logic [31:0] bm_data,
    output logic [4:0]  bm_nfields,
    output logic        bm_last
);

    state_t      r_state;
    logic [63:0] r_acc;
    logic [2:0]  r_acc_cnt;
    logic        r_pay_done;
    logic        r_pay_vld;
    logic [31:0] r_pay_dat;
    logic [2:0]  r_pay_nbytes;
    logic        r_pay_last;

    logic        w_in_rdy;
    logic        w_in_fire;
    logic        w_bm_block;
    logic        w_pay_free;
    logic [3:0]  w_add_len;
    logic [63:0] w_add_bytes;
    logic [63:0] w_sum;
    logic [3:0]  w_sum_cnt;
    logic        w_full_load;
    logic        w_fin_load;
    logic        w_flush;
    logic [3:0]  w_bm_cnt;
    logic        w_bm_fin_load;
    logic        w_pay_done_nxt;
    logic        w_bm_done_nxt;

    assign w_flush    = (r_state == FLUSH);
    // A 16th code can only be taken if the bitmap register is free or drains this cycle.
    assign w_bm_block = (w_bm_cnt == 4'd15) && bm_valid && !bm_ready;
    assign w_in_rdy   = rst_n && (r_state == RUN) && (r_acc_cnt <= 3'd3) && !w_bm_block;
    assign w_in_fire  = in_valid && w_in_rdy;
    assign w_pay_free = !r_pay_vld || pay_ready;

    // Accumulator contents after this cycle's input, before any word is pulled out.
    always_comb begin
        w_add_len   = 4'd0;
        w_add_bytes = 64'd0;
        if (w_in_fire) begin
            w_add_len   = {1'b0, code_len(in_bitmap)};
            w_add_bytes = {32'd0, code_bytes(in_bitmap, in_data)} << {r_acc_cnt, 3'b000};
        end
        w_sum     = r_acc | w_add_bytes;
        w_sum_cnt = {1'b0, r_acc_cnt} + w_add_len;
    end

    // Loading from the post-input sum gives the 1-cycle word latency. In FLUSH no
    // input is taken, so the tail word goes only once full words have drained.
    assign w_full_load    = (w_sum_cnt >= 4'd4) && w_pay_free;
    assign w_fin_load     = w_flush && !r_pay_done && (r_acc_cnt < 3'd4) && w_pay_free;
    assign w_pay_done_nxt = r_pay_done || w_fin_load;
    // The last beat always adds a code, so an empty bitmap accumulator in FLUSH means its final word already left.
    assign w_bm_done_nxt  = (w_bm_cnt == 4'd0) || w_bm_fin_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_acc        <= 64'd0;
            r_acc_cnt    <= 3'd0;
            r_pay_done   <= 1'b0;
            r_pay_vld    <= 1'b0;
            r_pay_dat    <= 32'd0;
            r_pay_nbytes <= 3'd0;
            r_pay_last   <= 1'b0;
        end else begin
            if (r_pay_vld && pay_ready) begin
                r_pay_vld <= 1'b0;
            end
            if (w_full_load) begin
                r_pay_vld    <= 1'b1;
                r_pay_dat    <= w_sum[31:0];
                r_pay_nbytes <= 3'd4;
                r_pay_last   <= 1'b0;
                r_acc        <= {32'd0, w_sum[63:32]};
                r_acc_cnt    <= w_sum_cnt[2:0] - 3'd4;
            end else if (w_fin_load) begin
                // Lanes above r_acc_cnt are always zero, so the tail word is already padded.
                r_pay_vld    <= 1'b1;
                r_pay_dat    <= r_acc[31:0];
                r_pay_nbytes <= r_acc_cnt;
                r_pay_last   <= 1'b1;
                r_acc        <= 64'd0;
                r_acc_cnt    <= 3'd0;
            end else begin
                r_acc     <= w_sum;
                r_acc_cnt <= w_sum_cnt[2:0];
            end

            case (r_state)
                RUN: begin
                    if (w_in_fire && in_last) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (w_pay_done_nxt && w_bm_done_nxt) begin
                        r_state    <= RUN;
                        r_pay_done <= 1'b0;
                    end else begin
                        r_pay_done <= w_pay_done_nxt;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    compress_bm_packer u_bm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_code_vld   (w_in_fire),
        .i_code       (in_bitmap),
        .i_last       (in_last),
        .i_flush      (w_flush),
        .i_bm_rdy     (bm_ready),
        .o_bm_vld     (bm_valid),
        .o_bm_dat     (bm_data),
        .o_bm_nfields (bm_nfields),
        .o_bm_last    (bm_last),
        .o_cnt        (w_bm_cnt),
        .o_fin_load   (w_bm_fin_load)
    );

    assign in_ready   = w_in_rdy;
    assign pay_valid  = r_pay_vld;
    assign pay_data   = r_pay_dat;
    assign pay_nbytes = r_pay_nbytes;
    assign pay_last   = r_pay_last;

endmodule

// File: tb/tb_compress_packer.sv
// Directed bench for compress_packer with a frame-level byte/code model and a per-cycle compare process.
// Latency: n/a.
// Backpressure: exercised by holding pay_ready / bm_ready low in selected scenarios.
module tb_compress_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_bitmap;
    logic [31:0] in_data;
    logic        in_last;
    logic        pay_valid;
    logic        pay_ready;
    logic [31:0] pay_data;
    logic [2:0]  pay_nbytes;
    logic        pay_last;
    logic        bm_valid;
    logic        bm_ready;
    logic [31:0] bm_data;
    logic [4:0]  bm_nfields;
    logic        bm_last;

    always #5 clk = ~clk;

    compress_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bitmap  (in_bitmap),
        .in_data    (in_data),
        .in_last    (in_last),
        .pay_valid  (pay_valid),
        .pay_ready  (pay_ready),
        .pay_data   (pay_data),
        .pay_nbytes (pay_nbytes),
        .pay_last   (pay_last),
        .bm_valid   (bm_valid),
        .bm_ready   (bm_ready),
        .bm_data    (bm_data),
        .bm_nfields (bm_nfields),
        .bm_last    (bm_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected words: pay = {last, nbytes, data}, bm = {last, nfields, data}.
    logic [35:0]  exp_pay[$];
    logic [37:0]  exp_bm[$];
    logic [35:0]  pay_log[$];
    logic [37:0]  bm_log[$];
    byte unsigned m_bytes[$];
    logic [1:0]   m_codes[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: bytes form one little-endian stream cut into 4-byte words,
    // codes are cut into groups of 16; the frame end flushes both tails.
    function automatic void model_accept(input logic [1:0] code, input logic [31:0] data, input logic last);
        int          n;
        logic [31:0] w;
        n = (code == 2'b00) ? 0 : (code == 2'b01) ? 1 : (code == 2'b10) ? 2 : 4;
        for (int i = 0; i < n; i++) m_bytes.push_back(data[8*i +: 8]);
        while (m_bytes.size() >= 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            for (int i = 0; i < 4; i++) void'(m_bytes.pop_front());
            exp_pay.push_back({1'b0, 3'd4, w});
        end
        m_codes.push_back(code);
        if (m_codes.size() == 16 || last) begin
            w = 32'd0;
            for (int i = 0; i < m_codes.size(); i++) w[2*i +: 2] = m_codes[i];
            exp_bm.push_back({last, 5'(m_codes.size()), w});
            m_codes.delete();
        end
        if (last) begin
            w = 32'd0;
            for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
            exp_pay.push_back({1'b1, 3'(m_bytes.size()), w});
            m_bytes.delete();
        end
    endfunction

    task automatic monitor_loop();
        logic        prev_pay_stall = 1'b0;
        logic        prev_bm_stall  = 1'b0;
        logic [35:0] prev_pay = '0;
        logic [37:0] prev_bm  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pay.delete();
                exp_bm.delete();
                m_bytes.delete();
                m_codes.delete();
                prev_pay_stall = 1'b0;
                prev_bm_stall  = 1'b0;
            end else begin
                if (prev_pay_stall) chk("pay_hold", {pay_valid, pay_last, pay_nbytes, pay_data}, {1'b1, prev_pay});
                if (prev_bm_stall)  chk("bm_hold", {bm_valid, bm_last, bm_nfields, bm_data}, {1'b1, prev_bm});
                if (in_valid && in_ready) model_accept(in_bitmap, in_data, in_last);
                if (pay_valid && pay_ready) begin
                    if (exp_pay.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL pay_unexpected: got 0x%0h, expected no word", {pay_last, pay_nbytes, pay_data});
                    end else begin
                        chk("pay_word", {pay_last, pay_nbytes, pay_data}, exp_pay.pop_front());
                    end
                    pay_log.push_back({pay_last, pay_nbytes, pay_data});
                end
                if (bm_valid && bm_ready) begin
                    if (exp_bm.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL bm_unexpected: got 0x%0h, expected no word", {bm_last, bm_nfields, bm_data});
                    end else begin
                        chk("bm_word", {bm_last, bm_nfields, bm_data}, exp_bm.pop_front());
                    end
                    bm_log.push_back({bm_last, bm_nfields, bm_data});
                end
                prev_pay_stall = pay_valid && !pay_ready;
                prev_pay       = {pay_last, pay_nbytes, pay_data};
                prev_bm_stall  = bm_valid && !bm_ready;
                prev_bm        = {bm_last, bm_nfields, bm_data};
            end
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [1:0] code, input logic [31:0] data, input logic last, output int waits);
        in_bitmap = code;
        in_data   = data;
        in_last   = last;
        in_valid  = 1'b1;
        waits     = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waits);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic [1:0] code, input logic [31:0] data, input logic last);
        int w;
        send_beat(code, data, last, w);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_pay.size() != 0 || exp_bm.size() != 0 || pay_valid || bm_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: got %0d pay / %0d bm words outstanding, expected 0", name, exp_pay.size(), exp_bm.size());
        end
        @(negedge clk);
        chk({name, "_idle_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pay(input string nm, input int idx, input logic [31:0] d, input logic [2:0] nb, input logic l);
        if (idx >= pay_log.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no word, expected 0x%0h", nm, {l, nb, d});
        end else begin
            chk(nm, pay_log[idx], {l, nb, d});
        end
    endtask

    task automatic chk_bm(input string nm, input int idx, input logic [31:0] d, input logic [4:0] nf, input logic l);
        if (idx >= bm_log.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no word, expected 0x%0h", nm, {l, nf, d});
        end else begin
            chk(nm, bm_log[idx], {l, nf, d});
        end
    endtask

    initial begin
        int p0;
        int b0;
        int w;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bitmap = 2'b00;
        in_data   = 32'd0;
        in_last   = 1'b0;
        pay_ready = 1'b1;
        bm_ready  = 1'b1;

        fork
            monitor_loop();
            begin
                #300000;
                $display("FAIL watchdog: got no completion, expected finish within time limit");
                $display("Simulation finished: %0d checks, %0d errors", n_checks + 1, n_errors + 1);
                $fatal(1);
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_flags", {pay_valid, bm_valid, in_ready}, 3'b000);
        chk("rst_pay", {pay_last, pay_nbytes, pay_data}, 36'd0);
        chk("rst_bm", {bm_last, bm_nfields, bm_data}, 38'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Two full words, back to back, no bubble
        p0 = pay_log.size();
        b0 = bm_log.size();
        send(2'b11, 32'h44332211, 1'b0);
        chk("s21_latency", {pay_valid, pay_data}, {1'b1, 32'h44332211});
        send(2'b11, 32'h88776655, 1'b1);
        chk("s21_no_bubble", {pay_valid, pay_data}, {1'b1, 32'h88776655});
        drain("s21");
        chk("s21_npay", pay_log.size() - p0, 3);
        chk_pay("s21_pay0", p0,     32'h44332211, 3'd4, 1'b0);
        chk_pay("s21_pay1", p0 + 1, 32'h88776655, 3'd4, 1'b0);
        chk_pay("s21_pay2", p0 + 2, 32'h00000000, 3'd0, 1'b1);
        chk_bm("s21_bm", b0, 32'h0000000F, 5'd2, 1'b1);

        // Mixed lengths filling exactly one word; upper data bits must be ignored
        p0 = pay_log.size();
        b0 = bm_log.size();
        send(2'b01, 32'h123456AA, 1'b0);
        send(2'b10, 32'h9999CCBB, 1'b0);
        send(2'b01, 32'hFFFFFFDD, 1'b1);
        drain("s22");
        chk("s22_npay", pay_log.size() - p0, 2);
        chk_pay("s22_pay0", p0,     32'hDDCCBBAA, 3'd4, 1'b0);
        chk_pay("s22_pay1", p0 + 1, 32'h00000000, 3'd0, 1'b1);
        chk_bm("s22_bm", b0, 32'h00000019, 5'd3, 1'b1);

        // Partial tail word of 3 bytes
        p0 = pay_log.size();
        b0 = bm_log.size();
        send(2'b10, 32'h7777BEEF, 1'b0);
        send(2'b01, 32'h0000005A, 1'b1);
        drain("stail");
        chk_pay("stail_pay0", p0, 32'h005ABEEF, 3'd3, 1'b1);
        chk_bm("stail_bm", b0, 32'h00000006, 5'd2, 1'b1);

        // 16 zero-length codes; bitmap word fills on the last beat
        p0 = pay_log.size();
        b0 = bm_log.size();
        for (int i = 0; i < 16; i++) send(2'b00, 32'hDEADBEEF, (i == 15));
        drain("s23");
        chk("s23_npay", pay_log.size() - p0, 1);
        chk("s23_nbm", bm_log.size() - b0, 1);
        chk_pay("s23_pay0", p0, 32'h00000000, 3'd0, 1'b1);
        chk_bm("s23_bm", b0, 32'h00000000, 5'd16, 1'b1);

        // Payload stall with 7 bytes accumulated
        p0 = pay_log.size();
        b0 = bm_log.size();
        pay_ready = 1'b0;
        send(2'b11, 32'h04030201, 1'b0);
        send(2'b01, 32'h00000005, 1'b0);
        send(2'b10, 32'h00000706, 1'b0);
        send(2'b11, 32'h0B0A0908, 1'b0);
        chk("s24_stall_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("s24_stall_hold", {in_ready, pay_valid, pay_data}, {1'b0, 1'b1, 32'h04030201});
        @(posedge clk);
        #1;
        pay_ready = 1'b1;
        send(2'b00, 32'h0, 1'b1);
        drain("s24");
        chk("s24_npay", pay_log.size() - p0, 3);
        chk_pay("s24_pay0", p0,     32'h04030201, 3'd4, 1'b0);
        chk_pay("s24_pay1", p0 + 1, 32'h08070605, 3'd4, 1'b0);
        chk_pay("s24_pay2", p0 + 2, 32'h000B0A09, 3'd3, 1'b1);
        chk_bm("s24_bm", b0, 32'h000000E7, 5'd5, 1'b1);

        // Bitmap stall: 16th code of the second word waits for the first word to drain
        p0 = pay_log.size();
        b0 = bm_log.size();
        bm_ready = 1'b0;
        for (int i = 0; i < 31; i++) send(2'b00, 32'd0, 1'b0);
        chk("s25_block", {in_ready, bm_valid, bm_nfields}, {1'b0, 1'b1, 5'd16});
        repeat (2) @(negedge clk);
        chk("s25_block_hold", in_ready, 0);
        @(posedge clk);
        #1;
        bm_ready = 1'b1;
        send_beat(2'b00, 32'd0, 1'b1, w);
        chk("s25_accept_wait", w, 0);
        drain("s25");
        chk("s25_nbm", bm_log.size() - b0, 2);
        chk_bm("s25_bm0", b0,     32'h00000000, 5'd16, 1'b0);
        chk_bm("s25_bm1", b0 + 1, 32'h00000000, 5'd16, 1'b1);
        chk_pay("s25_pay0", p0, 32'h00000000, 3'd0, 1'b1);

        // Reset while flushing with 2 bytes pending
        pay_ready = 1'b0;
        send(2'b11, 32'h11111111, 1'b0);
        send(2'b10, 32'h00002222, 1'b1);
        repeat (2) @(negedge clk);
        chk("s26_flush_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("s26_rst_flags", {pay_valid, bm_valid, in_ready}, 3'b000);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        pay_ready = 1'b1;
        p0 = pay_log.size();
        b0 = bm_log.size();
        send(2'b11, 32'hCAFEF00D, 1'b1);
        chk("s26_lane0", {pay_valid, pay_nbytes, pay_data}, {1'b1, 3'd4, 32'hCAFEF00D});
        drain("s26");
        chk("s26_npay", pay_log.size() - p0, 2);
        chk_pay("s26_pay0", p0,     32'hCAFEF00D, 3'd4, 1'b0);
        chk_pay("s26_pay1", p0 + 1, 32'h00000000, 3'd0, 1'b1);
        chk_bm("s26_bm", b0, 32'h00000003, 5'd1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
